// File: rtl/dir_nbr_gen_pkg.sv
// Shared definitions for the directional neighbour interface: disparity width,
// flag bit positions, the invalid-neighbour code and the producer FSM encoding.
package dir_nbr_gen_pkg;

  localparam int DWIDTH = 7;

  // Flag positions inside a flagged word {mismatch, occlusion, disp}
  localparam int OCC = DWIDTH;
  localparam int MIS = DWIDTH + 1;

  // Out-of-image neighbour: both flags set, disparity zero
  localparam logic [DWIDTH+1:0] INV = {2'b11, {DWIDTH{1'b0}}};

  // Producer FSM encoding
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

endpackage

// File: rtl/dir_nbr_gen_line_buf.sv
// Previous-row line buffer: single-port synchronous RAM with read-before-write.
// One access per accepted pixel returns the old word at that column while the
// new pixel overwrites it. Contents are deliberately not reset.
module nbr_line_buf #(
  parameter int DEPTH = 640,
  parameter int AW    = 10,
  parameter int W     = 9
) (
  input  logic          clk,
  input  logic          en,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);
  import dir_nbr_gen_pkg::*;

  logic [W-1:0] mem [DEPTH];

  // Read old word and write new word at the same address in one cycle
  always_ff @(posedge clk) begin
    if (en) begin
      rdata     <= mem[addr];
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/dir_nbr_gen.sv
// Directional neighbour generator: turns a raster stream of flagged
// disparities into per-centre windows (0, 45, 90, 135, 180) for the vote stage.
// A centre is emitted when its right neighbour arrives; the last column of each
// row is emitted by a one-cycle FLUSH state. Out-of-image taps carry INV.
module dir_nbr_gen #(
  parameter int DWIDTH = dir_nbr_gen_pkg::DWIDTH,
  parameter int IMG_W  = 640,
  parameter int CW     = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clken,
  input  logic                 in_valid,
  input  logic                 sof,
  input  logic [DWIDTH+1:0]    din,
  output logic [DWIDTH+1:0]    dout_45,
  output logic [DWIDTH+1:0]    dout_90,
  output logic [DWIDTH+1:0]    dout_135,
  output logic [2*DWIDTH+3:0]  dout_0_180,
  output logic                 enable,
  output logic                 ovf
);
  import dir_nbr_gen_pkg::*;

  localparam int W  = DWIDTH + 2;
  localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
  localparam logic [CW-1:0] ONE_COL  = CW'(1);
  localparam logic [W-1:0]  NBR_INV  = {2'b11, {DWIDTH{1'b0}}};

  // Source of the 45-degree tap, which is the RAM word read on the emitting edge
  localparam logic [1:0] SEL_ZERO = 2'd0;
  localparam logic [1:0] SEL_INV  = 2'd1;
  localparam logic [1:0] SEL_RAM  = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] col;
  logic [CW-1:0] row;
  logic [1:0]    sel45;

  // Current-row holding registers: pixel at col-1 and col-2
  logic [W-1:0]  pix_p1;
  logic [W-1:0]  pix_p2;
  // Previous-row taps: RAM output is prev[col-1], captured copy is prev[col-2]
  logic [W-1:0]  prv_p1;
  logic [W-1:0]  prv_p2;

  logic          acc_p0;
  logic          start_p0;
  logic [AW-1:0] ram_addr;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + ONE_COL;
  endfunction

  // Decode pixel acceptance: sof pixels start a frame, other RUN pixels advance it
  always_comb begin
    start_p0 = 1'b0;
    acc_p0   = 1'b0;
    if (clken && in_valid) begin
      if (state == IDLE) begin
        start_p0 = sof;
        acc_p0   = sof;
      end else if (state == RUN) begin
        start_p0 = sof;
        acc_p0   = 1'b1;
      end
    end
    ram_addr = start_p0 ? '0 : col[AW-1:0];
  end

  nbr_line_buf #(
    .DEPTH (IMG_W),
    .AW    (AW),
    .W     (W)
  ) u_line_buf (
    .clk   (clk),
    .en    (acc_p0),
    .addr  (ram_addr),
    .wdata (din),
    .rdata (prv_p1)
  );

  // Shift the current-row and previous-row holding registers on each accepted pixel
  always_ff @(posedge clk) begin
    if (acc_p0) begin
      pix_p2 <= pix_p1;
      pix_p1 <= din;
      prv_p2 <= prv_p1;
    end
  end

  // FSM, counters and window output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      ovf        <= 1'b0;
      enable     <= 1'b0;
      sel45      <= SEL_ZERO;
      dout_90    <= '0;
      dout_135   <= '0;
      dout_0_180 <= '0;
    end else if (clken) begin
      enable <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && sof) begin
            state <= RUN;
            col   <= ONE_COL;
            row   <= '0;
          end
        end
        RUN: begin
          if (in_valid) begin
            if (sof) begin
              // Pending centre is abandoned; this pixel is the new (0,0)
              col <= ONE_COL;
              row <= '0;
            end else begin
              if (col != '0) begin
                enable     <= 1'b1;
                sel45      <= (row == '0) ? SEL_INV : SEL_RAM;
                dout_90    <= (row == '0) ? NBR_INV : prv_p1;
                dout_135   <= ((row == '0) || (col == ONE_COL)) ? NBR_INV : prv_p2;
                dout_0_180 <= {((col == ONE_COL) ? NBR_INV : pix_p2), din};
              end
              if (col == LAST_COL) begin
                col   <= '0;
                state <= FLUSH;
              end else begin
                col <= col + ONE_COL;
              end
            end
          end
        end
        FLUSH: begin
          // Last column of the row: no right neighbour exists
          enable     <= 1'b1;
          sel45      <= SEL_INV;
          dout_90    <= (row == '0) ? NBR_INV : prv_p1;
          dout_135   <= (row == '0) ? NBR_INV : prv_p2;
          dout_0_180 <= {pix_p2, NBR_INV};
          row        <= sat_inc(row);
          if (in_valid) ovf <= 1'b1;
          state      <= sof ? IDLE : RUN;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // 45-degree tap comes straight from the RAM output register, or a forced code
  always_comb begin
    case (sel45)
      SEL_RAM: dout_45 = prv_p1;
      SEL_INV: dout_45 = NBR_INV;
      default: dout_45 = '0;
    endcase
  end

endmodule

// File: tb/tb_dir_nbr_gen.sv
// Bench for dir_nbr_gen with a 4-pixel row: table of vectors with hand-derived
// windows, a frame-based reference model for the other sequences, and a
// scoreboard queue popped whenever the DUT raises enable.
module tb_dir_nbr_gen;
  localparam int DW = 7;
  localparam int IW = 4;
  localparam int CWID = 10;
  localparam logic [8:0] INV = 9'h180;

  typedef struct packed {
    logic [8:0] l;   // 0 deg
    logic [8:0] r;   // 180 deg
    logic [8:0] u;   // 90 deg
    logic [8:0] ur;  // 45 deg
    logic [8:0] ul;  // 135 deg
  } win_t;

  typedef struct {
    logic       vld;
    logic       sof;
    logic [8:0] din;
    logic       emit;
    win_t       w;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clken = 1'b0;
  logic        in_valid = 1'b0;
  logic        sof = 1'b0;
  logic [8:0]  din = '0;
  logic [8:0]  dout_45, dout_90, dout_135;
  logic [17:0] dout_0_180;
  logic        enable, ovf;

  dir_nbr_gen #(.DWIDTH(DW), .IMG_W(IW), .CW(CWID)) dut (
    .clk        (clk),
    .rst        (rst),
    .clken      (clken),
    .in_valid   (in_valid),
    .sof        (sof),
    .din        (din),
    .dout_45    (dout_45),
    .dout_90    (dout_90),
    .dout_135   (dout_135),
    .dout_0_180 (dout_0_180),
    .enable     (enable),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_en  = 0;
  win_t        exp_q[$];
  logic [8:0]  img [2][4];
  vec_t        vt [10];
  logic        rand_ce = 1'b0;
  logic        gaps = 1'b0;
  logic        mon_on = 1'b0;
  logic        have_snap = 1'b0;
  logic        ce_edge = 1'b0;
  logic [46:0] snap;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, got, want);
    end
  endtask

  function automatic win_t mk(input logic [8:0] l, input logic [8:0] r, input logic [8:0] u,
                              input logic [8:0] ur, input logic [8:0] ul);
    win_t w;
    w.l = l; w.r = r; w.u = u; w.ur = ur; w.ul = ul;
    return w;
  endfunction

  // Reference window for centre (rr,cc) of the frame held in img
  function automatic win_t mwin(input int rr, input int cc);
    win_t w;
    w.l  = (cc == 0) ? INV : img[rr][cc-1];
    w.r  = (cc == IW-1) ? INV : img[rr][cc+1];
    w.u  = (rr == 0) ? INV : img[rr-1][cc];
    w.ur = (rr == 0 || cc == IW-1) ? INV : img[rr-1][cc+1];
    w.ul = (rr == 0 || cc == 0) ? INV : img[rr-1][cc-1];
    return w;
  endfunction

  // Present one input word until a clken=1 edge consumes it
  task automatic apply(input logic v, input logic s, input logic [8:0] d);
    logic ce;
    in_valid = v;
    sof      = s;
    din      = d;
    for (int t = 0; t < 4; t++) begin
      clken = (rand_ce && t < 3) ? 1'($urandom_range(0, 1)) : 1'b1;
      ce    = clken;
      @(posedge clk);
      #1;
      if (ce) break;
    end
    in_valid = 1'b0;
    sof      = 1'b0;
  endtask

  task automatic run_table();
    for (int k = 0; k < 10; k++) begin
      if (gaps && vt[k].vld) begin
        int ng;
        ng = $urandom_range(0, 2);
        for (int g = 0; g < ng; g++) apply(1'b0, 1'b0, 9'h1FF);
      end
      if (vt[k].emit) exp_q.push_back(vt[k].w);
      apply(vt[k].vld, vt[k].sof, vt[k].din);
    end
  endtask

  task automatic send_row(input int rr, input logic first, input logic inj);
    for (int c = 0; c < IW; c++) begin
      if (c > 0) exp_q.push_back(mwin(rr, c - 1));
      apply(1'b1, first && (c == 0), img[rr][c]);
    end
    exp_q.push_back(mwin(rr, IW - 1));
    apply(inj, 1'b0, 9'h063);
  endtask

  task automatic drain(input string nm);
    logic keep;
    keep    = rand_ce;
    rand_ce = 1'b0;
    repeat (4) apply(1'b0, 1'b0, 9'h000);
    rand_ce = keep;
    chk(nm, 64'(exp_q.size()), 64'd0);
  endtask

  always @(posedge clk) ce_edge <= clken;

  // Scoreboard: pop on every enable seen at a clken edge; hold check on stalls
  always @(negedge clk) begin
    logic [46:0] cur;
    win_t        got, e;
    cur = {dout_0_180, dout_90, dout_45, dout_135, enable, ovf};
    if (!mon_on) begin
      have_snap = 1'b0;
    end else begin
      if (have_snap && !ce_edge) chk("stall_hold", 64'(cur), 64'(snap));
      if (clken && enable) begin
        n_en++;
        got = {dout_0_180, dout_90, dout_45, dout_135};
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_enable: got window=%0h want no enable", got);
        end else begin
          e = exp_q.pop_front();
          chk("window", 64'(got), 64'(e));
        end
      end
      snap      = cur;
      have_snap = 1'b1;
    end
  end

  initial begin
    int n0;
    // Basic frame: row 0 = 1..4, row 1 = 5..8, one idle (flush) cycle per row
    vt[0] = '{1'b1, 1'b1, 9'd1, 1'b0, '0};
    vt[1] = '{1'b1, 1'b0, 9'd2, 1'b1, mk(INV,  9'd2, INV,  INV,  INV)};
    vt[2] = '{1'b1, 1'b0, 9'd3, 1'b1, mk(9'd1, 9'd3, INV,  INV,  INV)};
    vt[3] = '{1'b1, 1'b0, 9'd4, 1'b1, mk(9'd2, 9'd4, INV,  INV,  INV)};
    vt[4] = '{1'b0, 1'b0, 9'd0, 1'b1, mk(9'd3, INV,  INV,  INV,  INV)};
    vt[5] = '{1'b1, 1'b0, 9'd5, 1'b0, '0};
    vt[6] = '{1'b1, 1'b0, 9'd6, 1'b1, mk(INV,  9'd6, 9'd1, 9'd2, INV)};
    vt[7] = '{1'b1, 1'b0, 9'd7, 1'b1, mk(9'd5, 9'd7, 9'd2, 9'd3, 9'd1)};
    vt[8] = '{1'b1, 1'b0, 9'd8, 1'b1, mk(9'd6, 9'd8, 9'd3, 9'd4, 9'd2)};
    vt[9] = '{1'b0, 1'b0, 9'd0, 1'b1, mk(9'd7, INV,  9'd4, INV,  9'd3)};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_dout_0_180", 64'(dout_0_180), 64'd0);
    chk("reset_dout_90",    64'(dout_90),    64'd0);
    chk("reset_dout_45",    64'(dout_45),    64'd0);
    chk("reset_dout_135",   64'(dout_135),   64'd0);
    chk("reset_enable",     64'(enable),     64'd0);
    chk("reset_ovf",        64'(ovf),        64'd0);
    rst    = 1'b1;
    mon_on = 1'b1;

    // Basic frame, then the same frame again over a buffer full of row 1
    run_table();
    drain("drain_frame1");
    run_table();
    drain("drain_frame2_stale");

    // Random clken stalls and input gaps: same windows, 8 pulses
    n0      = n_en;
    rand_ce = 1'b1;
    gaps    = 1'b1;
    run_table();
    drain("drain_random");
    rand_ce = 1'b0;
    gaps    = 1'b0;
    chk("random_enable_pulses", 64'(n_en - n0), 64'd8);

    // Flag passthrough: occlusion-flagged word at (0,1)
    img[0] = '{9'd1, 9'h0AA, 9'd3, 9'd4};
    img[1] = '{9'd5, 9'd6,   9'd7, 9'd8};
    send_row(0, 1'b1, 1'b0);
    send_row(1, 1'b0, 1'b0);
    drain("drain_flags");

    // sof mid-row: centre (0,1) of the abandoned frame must not appear
    exp_q.push_back(mk(INV, 9'd2, INV, INV, INV));
    apply(1'b1, 1'b1, 9'd1);
    apply(1'b1, 1'b0, 9'd2);
    img[0] = '{9'd10, 9'd11, 9'd12, 9'd13};
    img[1] = '{9'd20, 9'd21, 9'd22, 9'd23};
    send_row(0, 1'b1, 1'b0);
    send_row(1, 1'b0, 1'b0);
    drain("drain_sof_midrow");

    // Pixel during FLUSH: dropped, ovf sticky, following row unaffected
    chk("ovf_before", 64'(ovf), 64'd0);
    img[0] = '{9'd31, 9'd32, 9'd33, 9'd34};
    img[1] = '{9'd41, 9'd42, 9'd43, 9'd44};
    send_row(0, 1'b1, 1'b1);
    chk("ovf_set", 64'(ovf), 64'd1);
    send_row(1, 1'b0, 1'b0);
    drain("drain_ovf");
    chk("ovf_sticky", 64'(ovf), 64'd1);

    // Async reset mid-row, then stray pixels without sof produce nothing
    exp_q.push_back(mk(INV, 9'd2, INV, INV, INV));
    exp_q.push_back(mk(9'd1, 9'd3, INV, INV, INV));
    apply(1'b1, 1'b1, 9'd1);
    apply(1'b1, 1'b0, 9'd2);
    apply(1'b1, 1'b0, 9'd3);
    apply(1'b0, 1'b0, 9'd0);
    chk("pre_reset_queue", 64'(exp_q.size()), 64'd0);
    mon_on = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("areset_windows", 64'({dout_0_180, dout_90, dout_45, dout_135}), 64'd0);
    chk("areset_enable",  64'(enable), 64'd0);
    chk("areset_ovf",     64'(ovf),    64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    mon_on = 1'b1;
    n0 = n_en;
    for (int c = 0; c < IW; c++) apply(1'b1, 1'b0, 9'(50 + c));
    repeat (3) apply(1'b0, 1'b0, 9'd0);
    chk("no_output_before_sof", 64'(n_en - n0), 64'd0);

    // Normal frame after reset release
    img[0] = '{9'd61, 9'd62, 9'd63, 9'd64};
    img[1] = '{9'd71, 9'd72, 9'd73, 9'd74};
    n0 = n_en;
    send_row(0, 1'b1, 1'b0);
    send_row(1, 1'b0, 1'b0);
    drain("drain_after_reset");
    chk("after_reset_pulses", 64'(n_en - n0), 64'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
